// File: rtl/mandel_sched_pkg.sv
// Shared types and defaults for the dual-engine mandelbrot frame scheduler.
// Optional frame cycle counter is enabled with SCHED_PERF_CTR_EN.
package mandel_sched_pkg;
  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN
  } state_t;

  localparam int DEF_CW     = 4;
  localparam int DEF_WIDTH  = 400;
  localparam int DEF_HEIGHT = 300;
endpackage

// File: rtl/mandel_result_slot.sv
// Per-engine job tracker: busy flag, one-entry result buffer and
// the dispatchable condition (engine idle and buffer empty).
module mandel_result_slot
  import mandel_sched_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          combined_rst_n,
  input  logic          clr,
  input  logic          dispatch,
  input  logic          done,
  input  logic [CW-1:0] ctr,
  input  logic          take,
  output logic          run,
  output logic          valid,
  output logic [CW-1:0] data,
  output logic          ready
);

  assign ready = !run && !valid;

  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      run   <= 1'b0;
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      run   <= 1'b0;
      valid <= 1'b0;
    end else begin
      if (dispatch) run <= 1'b1;
      // a done pulse counts only while a job is outstanding
      if (done && run) begin
        run   <= 1'b0;
        valid <= 1'b1;
        data  <= ctr;
      end
      if (take) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mandel_dual_scheduler.sv
// Raster scheduler feeding two engines alternately and writing results in order.
// Define SCHED_PERF_CTR_EN to add the frame_cycles counter output.
module mandel_dual_scheduler
  import mandel_sched_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT),
  parameter int CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          combined_rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [1:0]    eng_start,
  output logic          eng_abort,
  output logic [XW-1:0] eng_px_x,
  output logic [YW-1:0] eng_px_y,
  input  logic [1:0]    eng_done,
  input  logic [CW-1:0] eng_ctr0,
  input  logic [CW-1:0] eng_ctr1,
  output logic          fb_reset_ptr,
  output logic          fb_write,
  output logic [CW-1:0] fb_data,
  input  logic          fb_wrote,
  output logic          busy,
  output logic          frame_done
`ifdef SCHED_PERF_CTR_EN
  ,
  output logic [23:0]   frame_cycles
`endif
);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          disp_sel;
  logic          wr_sel;
  logic          wr_pend;
  logic [1:0]    slot_run;
  logic [1:0]    slot_valid;
  logic [1:0]    slot_rdy;
  logic [1:0]    disp_vec;
  logic [1:0]    take_vec;
  logic [CW-1:0] slot_data0;
  logic [CW-1:0] slot_data1;
  logic [CW-1:0] wr_data;
  logic          disp_go;
  logic          wr_go;
  logic          wr_ack;
  logic          drained;
  logic          x_last;
  logic          y_last;

  always_comb begin
    disp_go  = (state == RUN) && slot_rdy[disp_sel];
    disp_vec = disp_sel ? 2'b10 : 2'b01;
    wr_go    = (state inside {RUN, DRAIN}) && !wr_pend
             && slot_valid[wr_sel];
    wr_ack   = fb_wrote && wr_pend;
    take_vec = wr_ack ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
    wr_data  = wr_sel ? slot_data1 : slot_data0;
    drained  = ~|slot_run && ~|slot_valid && !wr_pend;
    x_last   = x == XW'(WIDTH - 1);
    y_last   = y == YW'(HEIGHT - 1);
  end

  mandel_result_slot #(.CW(CW)) u_slot0 (
    .clk            (clk),
    .combined_rst_n (combined_rst_n),
    .clr            (abort),
    .dispatch       (disp_go && disp_vec[0] && !abort),
    .done           (eng_done[0]),
    .ctr            (eng_ctr0),
    .take           (take_vec[0]),
    .run            (slot_run[0]),
    .valid          (slot_valid[0]),
    .data           (slot_data0),
    .ready          (slot_rdy[0])
  );

  mandel_result_slot #(.CW(CW)) u_slot1 (
    .clk            (clk),
    .combined_rst_n (combined_rst_n),
    .clr            (abort),
    .dispatch       (disp_go && disp_vec[1] && !abort),
    .done           (eng_done[1]),
    .ctr            (eng_ctr1),
    .take           (take_vec[1]),
    .run            (slot_run[1]),
    .valid          (slot_valid[1]),
    .data           (slot_data1),
    .ready          (slot_rdy[1])
  );

  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      eng_start    <= '0;
      eng_abort    <= 1'b0;
      eng_px_x     <= '0;
      eng_px_y     <= '0;
      fb_reset_ptr <= 1'b0;
      fb_write     <= 1'b0;
      fb_data      <= '0;
      frame_done   <= 1'b0;
      x            <= '0;
      y            <= '0;
      disp_sel     <= 1'b0;
      wr_sel       <= 1'b0;
      wr_pend      <= 1'b0;
    end else begin
      eng_start    <= '0;
      eng_abort    <= 1'b0;
      fb_reset_ptr <= 1'b0;
      fb_write     <= 1'b0;
      frame_done   <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        eng_abort <= 1'b1;
        wr_pend   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= CLEAR;
              busy  <= 1'b1;
            end
          end
          CLEAR: begin
            fb_reset_ptr <= 1'b1;
            x            <= '0;
            y            <= '0;
            disp_sel     <= 1'b0;
            wr_sel       <= 1'b0;
            state        <= RUN;
          end
          RUN: begin
            if (disp_go) begin
              eng_start <= disp_vec;
              eng_px_x  <= x;
              eng_px_y  <= y;
              disp_sel  <= ~disp_sel;
              if (x_last) begin
                x <= '0;
                if (y_last) state <= DRAIN;
                else        y     <= y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (drained) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
        endcase
        if (wr_go) begin
          fb_write <= 1'b1;
          fb_data  <= wr_data;
          wr_pend  <= 1'b1;
        end else if (wr_ack) begin
          wr_sel  <= ~wr_sel;
          wr_pend <= 1'b0;
        end
      end
    end
  end

`ifdef SCHED_PERF_CTR_EN
  always_ff @(posedge clk or negedge combined_rst_n) begin
    if (!combined_rst_n) begin
      frame_cycles <= '0;
    end else if (state == CLEAR) begin
      frame_cycles <= '0;
    end else if ((state inside {RUN, DRAIN}) && frame_cycles != '1) begin
      frame_cycles <= frame_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mandel_dual_scheduler.sv
// Directed bench for mandel_dual_scheduler on a 4x2 raster with
// behavioural engines and a framebuffer acknowledging after a set delay.
module tb_mandel_dual_scheduler;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int NPX = W * H;

  logic       clk = 1'b0;
  logic       combined_rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] eng_start;
  logic       eng_abort;
  logic [1:0] eng_px_x;
  logic [0:0] eng_px_y;
  logic [1:0] eng_done = '0;
  logic [3:0] eng_ctr0 = '0;
  logic [3:0] eng_ctr1 = '0;
  logic       fb_reset_ptr;
  logic       fb_write;
  logic [3:0] fb_data;
  logic       fb_wrote = 1'b0;
  logic       busy;
  logic       frame_done;
`ifdef SCHED_PERF_CTR_EN
  logic [23:0] frame_cycles;
`endif

  always #5 clk = ~clk;

  mandel_dual_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk            (clk),
    .combined_rst_n (combined_rst_n),
    .start          (start),
    .abort          (abort),
    .eng_start      (eng_start),
    .eng_abort      (eng_abort),
    .eng_px_x       (eng_px_x),
    .eng_px_y       (eng_px_y),
    .eng_done       (eng_done),
    .eng_ctr0       (eng_ctr0),
    .eng_ctr1       (eng_ctr1),
    .fb_reset_ptr   (fb_reset_ptr),
    .fb_write       (fb_write),
    .fb_data        (fb_data),
    .fb_wrote       (fb_wrote),
    .busy           (busy),
    .frame_done     (frame_done)
`ifdef SCHED_PERF_CTR_EN
    ,
    .frame_cycles   (frame_cycles)
`endif
  );

  // engine result for pixel p is (3p+5) mod 16
  logic [3:0] exp_px [NPX] = '{4'd5, 4'd8, 4'd11, 4'd14,
                               4'd1, 4'd4, 4'd7, 4'd10};

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  int lat [2];
  int ack_dly;
  bit busy_e [2];
  bit full [2];
  int cnt_e [2];
  int pix_e [2];
  bit wpend;
  int wcnt;
  logic [3:0] wdata;
  int nwr, nack, ndisp, nfd, nrptr, nabort;
  int rptr_cyc, disp1_cyc, fd_cyc, abort_cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] eng_val(input int p);
    return 4'((p * 3 + 5) % 16);
  endfunction

  task automatic reset_model();
    for (int e = 0; e < 2; e++) begin
      busy_e[e] = 0;
      full[e]   = 0;
      cnt_e[e]  = 0;
      pix_e[e]  = 0;
    end
    wpend = 0; wcnt = 0; wdata = '0;
    nwr = 0; nack = 0; ndisp = 0; nfd = 0; nrptr = 0; nabort = 0;
    rptr_cyc = 0; disp1_cyc = 0; fd_cyc = 0; abort_cyc = 0;
  endtask

  task automatic step();
    int px;
    bit skip [2];
    @(posedge clk);
    #1;
    cyc++;
    start = 0; abort = 0; eng_done = '0; fb_wrote = 0;
    skip[0] = 0; skip[1] = 0;
    for (int e = 0; e < 2; e++) begin
      if (eng_start[e]) begin
        px = int'(eng_px_y) * W + int'(eng_px_x);
        chk("disp_eng", e, ndisp % 2);
        chk("disp_px", px, ndisp);
        chk("disp_free", {busy_e[e], full[e]}, 0);
        if (ndisp == 0) disp1_cyc = cyc;
        ndisp++;
        busy_e[e] = 1; cnt_e[e] = lat[e]; pix_e[e] = px; skip[e] = 1;
      end
    end
    if (fb_reset_ptr) begin nrptr++; rptr_cyc = cyc; end
    if (frame_done) begin nfd++; fd_cyc = cyc; end
    if (eng_abort) begin nabort++; abort_cyc = cyc; end
    if (fb_write) begin
      chk("wr_overlap", wpend, 0);
      chk("wr_data", fb_data, exp_px[nwr % NPX]);
      wpend = 1; wcnt = ack_dly; wdata = fb_data; nwr++;
    end else if (wpend) begin
      wcnt--;
      if (wcnt == 0) begin
        fb_wrote = 1; wpend = 0;
        chk("wr_hold", fb_data, wdata);
        full[nack % 2] = 0;
        nack++;
      end
    end
    for (int e = 0; e < 2; e++) begin
      if (busy_e[e] && !skip[e]) begin
        cnt_e[e]--;
        if (cnt_e[e] == 0) begin
          busy_e[e] = 0; full[e] = 1; eng_done[e] = 1;
          if (e == 0) eng_ctr0 = eng_val(pix_e[0]);
          else        eng_ctr1 = eng_val(pix_e[1]);
        end
      end
    end
  endtask

  task automatic run_frame(input int l0, input int l1, input int ad,
                           input int rs_at);
    int st;
    reset_model();
    lat[0] = l0; lat[1] = l1; ack_dly = ad;
    st = cyc;
    start = 1;
    for (int i = 0; i < 3000 && nfd == 0; i++) begin
      step();
      if (rs_at > 0 && cyc - st == rs_at) start = 1;
    end
    repeat (6) step();
    chk("n_fd", nfd, 1);
    chk("n_wr", nwr, NPX);
    chk("n_ack", nack, NPX);
    chk("n_disp", ndisp, NPX);
    chk("n_rptr", nrptr, 1);
    chk("rptr_lat", rptr_cyc - st, 2);
    chk("disp_lat", disp1_cyc - st, 3);
    chk("busy_end", busy, 0);
`ifdef SCHED_PERF_CTR_EN
    chk("perf_cyc", frame_cycles, fd_cyc - rptr_cyc);
`endif
  endtask

  initial begin
    reset_model();
    lat[0] = 3; lat[1] = 3; ack_dly = 1;
    #22;
    chk("rst_init", {eng_start, eng_abort, eng_px_x, eng_px_y,
        fb_reset_ptr, fb_write, fb_data, busy, frame_done}, 0);
    @(negedge clk);
    combined_rst_n = 1;
    step();
    chk("idle_busy", busy, 0);

    // reset asserted in the middle of a frame
    reset_model();
    start = 1;
    repeat (14) step();
    chk("mid_busy", busy, 1);
    #2;
    combined_rst_n = 0;
    #1;
    chk("rst_async", {eng_start, eng_abort, eng_px_x, eng_px_y,
        fb_reset_ptr, fb_write, fb_data, busy, frame_done}, 0);
    @(negedge clk);
    combined_rst_n = 1;
    reset_model();
    repeat (4) step();
    chk("rst_idle", busy, 0);
    chk("rst_nodisp", ndisp, 0);

    run_frame(3, 3, 1, 0);
    run_frame(20, 2, 1, 0);
    run_frame(3, 3, 15, 0);

    // abort after three writes, then a stray completion
    reset_model();
    lat[0] = 3; lat[1] = 3; ack_dly = 1;
    start = 1;
    for (int i = 0; i < 500 && nwr < 3; i++) step();
    chk("ab_reach3", nwr, 3);
    abort = 1;
    step();
    chk("ab_pulse", eng_abort, 1);
    chk("ab_busy", busy, 0);
    eng_done = 2'b11;
    eng_ctr0 = 4'd9;
    eng_ctr1 = 4'd9;
    repeat (40) step();
    chk("ab_no_fd", nfd, 0);
    chk("ab_wr", nwr, 3);
    chk("ab_cnt", nabort, 1);
    chk("ab_idle", busy, 0);
    chk("ab_fbw", fb_write, 0);
    run_frame(3, 3, 1, 0);

    // start during RUN is ignored
    run_frame(3, 3, 1, 10);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
